// File: rtl/fifo_burst_writer.sv
// Drains a line FIFO into fixed-length DDR write bursts: one (addr, len) command, then len words with last.
// Two-entry skid buffer covers the FIFO's one-cycle read latency so wr_ready may drop on any cycle.
module fifo_burst_writer #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned LEVEL_WIDTH = 12,
  parameter int unsigned BURST_LEN   = 64,
  parameter int unsigned ADDR_WIDTH  = 28,
  parameter int unsigned FRAME_WIDTH = 22
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   frame_start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [FRAME_WIDTH-1:0] frame_words,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_level,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [ADDR_WIDTH-1:0]  cmd_addr,
  output logic [8:0]             cmd_len,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_last,
  output logic                   busy,
  output logic                   frame_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CMD,
    S_DATA
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]  addr;
  logic [FRAME_WIDTH-1:0] remaining;
  logic [8:0]             blen;
  logic [8:0]             blen_c;
  logic [8:0]             issued;
  logic [8:0]             accepted;
  logic [DATA_WIDTH-1:0]  sk0;
  logic [DATA_WIDTH-1:0]  sk1;
  logic [1:0]             sk_cnt;
  logic                   in_flight;
  logic                   pop;
  logic                   burst_end;
  logic                   frame_last;
  logic                   level_ok;
  logic [1:0]             occ_after;

  assign blen_c   = (remaining >= FRAME_WIDTH'(BURST_LEN)) ? 9'(BURST_LEN) : remaining[8:0];
  assign level_ok = 32'(fifo_rd_level) >= 32'(blen_c);

  // The word returning from last cycle's read is presented directly when the skid is empty.
  assign wr_valid = (sk_cnt != 2'd0) || in_flight;
  assign wr_data  = (sk_cnt != 2'd0) ? sk0 : (in_flight ? fifo_rd_data : '0);
  assign wr_last  = wr_valid && (accepted == blen - 9'd1);
  assign pop      = wr_valid && wr_ready;

  assign occ_after  = sk_cnt + {1'b0, in_flight} - {1'b0, pop};
  assign fifo_rd_en = (state == S_DATA) && (issued < blen) && !fifo_rd_empty && (occ_after < 2'd2);

  assign burst_end  = (state == S_DATA) && pop && (accepted == blen - 9'd1);
  assign frame_last = (remaining == FRAME_WIDTH'(blen));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (frame_start && (frame_words != '0)) state_nxt = S_WAIT;
      S_WAIT: if (enable && level_ok) state_nxt = S_CMD;
      S_CMD:  if (cmd_ready) state_nxt = S_DATA;
      S_DATA: if (burst_end) state_nxt = frame_last ? S_IDLE : S_WAIT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr       <= '0;
      remaining  <= '0;
      blen       <= '0;
      issued     <= '0;
      accepted   <= '0;
      cmd_valid  <= 1'b0;
      cmd_addr   <= '0;
      cmd_len    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            addr      <= base_addr;
            remaining <= frame_words;
            if (frame_words == '0) begin
              frame_done <= 1'b1;
            end else begin
              busy <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (enable && level_ok) begin
            cmd_valid <= 1'b1;
            cmd_addr  <= addr;
            cmd_len   <= blen_c;
            blen      <= blen_c;
          end
        end
        S_CMD: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            issued    <= '0;
            accepted  <= '0;
          end
        end
        S_DATA: begin
          if (fifo_rd_en) begin
            issued <= issued + 9'd1;
          end
          if (pop) begin
            accepted <= accepted + 9'd1;
          end
          if (burst_end) begin
            addr      <= addr + ADDR_WIDTH'(blen);
            remaining <= remaining - FRAME_WIDTH'(blen);
            if (frame_last) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Skid buffer: sk0 is the head; a returning read either passes through, queues, or refills the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      sk0       <= '0;
      sk1       <= '0;
      sk_cnt    <= 2'd0;
      in_flight <= 1'b0;
    end else begin
      in_flight <= fifo_rd_en;
      case (sk_cnt)
        2'd0: begin
          if (in_flight && !pop) begin
            sk0    <= fifo_rd_data;
            sk_cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (pop && in_flight) begin
            sk0 <= fifo_rd_data;
          end else if (pop) begin
            sk_cnt <= 2'd0;
          end else if (in_flight) begin
            sk1    <= fifo_rd_data;
            sk_cnt <= 2'd2;
          end
        end
        default: begin
          if (pop) begin
            sk0 <= sk1;
            if (in_flight) begin
              sk1 <= fifo_rd_data;
            end else begin
              sk_cnt <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_burst_writer.md
Name: fifo_burst_writer

Overview:
- Downstream consumer of the 16-bit x 2048 synchronous line FIFO.
- Drains buffered video words in fixed-length bursts toward the DDR write port.
- Issues one command (address, length) per burst, then streams exactly that many words with valid/ready/last.
- Tracks a frame's word budget, so the final burst of a frame may be shorter than nominal.

Parameters:
- DATA_WIDTH, 16, FIFO and output data width.
- LEVEL_WIDTH, 12, width of the FIFO read water level (depth bits + 1).
- BURST_LEN, 64, nominal words per burst; must be ≤ 256 and ≤ FIFO depth.
- ADDR_WIDTH, 28, word-address width.
- FRAME_WIDTH, 22, width of the frame word counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  0 = no new bursts start; a burst in progress completes
- frame_start  in  1  pulse: load base_addr/frame_words; honoured only in IDLE
- base_addr  in  ADDR_WIDTH  frame base word address
- frame_words  in  FRAME_WIDTH  words in the frame; 0 = frame completes at once
- fifo_rd_en  out  1  FIFO read strobe
- fifo_rd_data  in  DATA_WIDTH  FIFO data, valid one cycle after fifo_rd_en
- fifo_rd_empty  in  1  FIFO empty flag
- fifo_rd_level  in  LEVEL_WIDTH  FIFO read water level
- cmd_valid  out  1  burst command valid
- cmd_ready  in  1  burst command accepted
- cmd_addr  out  ADDR_WIDTH  burst start word address
- cmd_len  out  9  burst length in words (1..BURST_LEN)
- wr_valid  out  1  write data valid
- wr_ready  in  1  write data accepted
- wr_data  out  DATA_WIDTH  write data
- wr_last  out  1  marks the last word of the burst
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse when the frame's last word is accepted

Behaviour:
- Reset: every output is 0. The FSM returns to IDLE; the address, remaining, issued and accepted counters and the skid buffer clear.
- Reset has priority over all other inputs, including mid-burst. No partial-burst recovery; the FIFO is reset by its owner.

States:
- IDLE
  - On frame_start: load addr = base_addr and remaining = frame_words.
  - If frame_words == 0: pulse frame_done next cycle and stay in IDLE.
  - Otherwise: set busy and go to WAIT.
- WAIT
  - blen = min(BURST_LEN, remaining).
  - When enable = 1 and fifo_rd_level ≥ blen: go to CMD.
  - Drive cmd_addr = addr and cmd_len = blen, registered on entry to CMD.
- CMD
  - Hold cmd_valid = 1 with stable addr/len until cmd_ready.
  - On the handshake cycle: cmd_valid falls and the FSM goes to DATA.
- DATA
  - Assert fifo_rd_en only when issued < blen, fifo_rd_empty = 0, and (buffered + in_flight) < 2 after this cycle's pop.
  - The 2-entry skid buffer absorbs the 1-cycle read latency, so wr_ready may drop at any cycle without losing a word.
  - wr_data / wr_valid come from the skid head.
  - wr_last = 1 when accepted == blen - 1.
  - A word transfers when wr_valid && wr_ready.
  - After the last transfer:
    - addr += blen, with modular ADDR_WIDTH wrap;
    - remaining -= blen;
    - if remaining == 0: frame_done pulses, busy drops, go to IDLE;
    - else go to WAIT.
- Bursts never span frames; cmd_len is never 0.
- frame_start outside IDLE is ignored.
- fifo_rd_en is never asserted while fifo_rd_empty = 1.
- Total fifo_rd_en pulses per burst equals cmd_len exactly.
- Latency:
  - WAIT→CMD: 1 cycle after the level condition.
  - First wr_valid: 2 cycles after the cmd handshake, when wr_ready = 1 and the FIFO is non-empty.
- Throughput: one word per cycle sustained while wr_ready = 1.

Test Plan:
- Nominal frame: frame_words = 192, base_addr = 0x100, FIFO pre-filled with 192 words, wr_ready = 1.
  -> Three commands (0x100/64, 0x140/64, 0x180/64); 192 words in FIFO order; wr_last on words 63, 127, 191; one frame_done pulse.
- Short tail: frame_words = 100, FIFO holds 100 words.
  -> Commands of len 64 then 36; the second burst starts once level ≥ 36; wr_last on word 99.
- Backpressure: wr_ready toggles 1,0,0,1 repeatedly during a 64-word burst.
  -> No word dropped or duplicated; data sequence intact; exactly 64 fifo_rd_en pulses; the skid never exceeds 2 entries.
- Starvation and cmd stall: level sits at 63 with BURST_LEN = 64 and cmd_ready held low for 10 cycles.
  -> cmd_valid stays 0 until level hits 64; then cmd_valid is held high 10 cycles with stable cmd_addr/cmd_len.
- Reset mid-burst: rst = 1 after 20 words of a 64-word burst, then a new frame of 64 words.
  -> All outputs 0 on the cycle after reset; the new frame restarts at its own base_addr with a clean count.
- Edge controls:
  -> frame_words = 0 gives frame_done one cycle after frame_start with no command.
  -> frame_start while busy is ignored.
  -> enable = 0 in WAIT holds off cmd_valid.
